// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache that issues 128-bit line reads to instruction_memory.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module instruction_cache #(
  parameter int IDX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  input  logic         FLUSH,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         INST_MEM_READ,
  output logic [27:0]  INST_MEM_ADDRESS,
  input  logic [127:0] INST_MEM_READDATA,
  input  logic         INST_MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 28 - IDX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_UPDATE
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag [LINES];
  logic [127:0]          r_data [LINES];
  logic [127:0]          r_fillData;
  logic [27:0]           r_addr;
  logic                  r_read;
  logic                  r_pendFlush;

  logic [IDX_BITS-1:0]   w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [IDX_BITS-1:0]   w_fillIdx;
  logic [TAG_BITS-1:0]   w_fillTag;
  logic [127:0]          w_line;
  logic [31:0]           w_word;
  logic                  w_hit;
  logic [1:0]            w_unused;

  assign w_idx     = PC[4 +: IDX_BITS];
  assign w_tag     = PC[31 -: TAG_BITS];
  assign w_fillIdx = r_addr[IDX_BITS-1:0];
  assign w_fillTag = r_addr[27 -: TAG_BITS];
  assign w_line    = r_data[w_idx];
  assign w_word    = w_line[{PC[3:2], 5'b00000} +: 32];
  assign w_hit     = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused  = PC[1:0];

  assign INST_MEM_READ    = r_read;
  assign INST_MEM_ADDRESS = r_addr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (!w_hit) w_nextState = S_MEM_REQ;
      S_MEM_REQ:  if (INST_MEM_BUSYWAIT) w_nextState = S_MEM_WAIT;
      S_MEM_WAIT: if (!INST_MEM_BUSYWAIT) w_nextState = S_UPDATE;
      S_UPDATE:   w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT    = 1'b1;
    INSTRUCTION = 32'h0;
    if (w_hit) begin
      BUSYWAIT    = 1'b0;
      INSTRUCTION = w_word;
    end
  end

  // Request lines stay registered so the memory sees them stable for the whole fill.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_read     <= 1'b0;
      r_addr     <= 28'h0;
      r_fillData <= 128'h0;
    end else begin
      r_read <= (w_nextState == S_MEM_REQ) || (w_nextState == S_MEM_WAIT);
      if (r_state == S_IDLE && !w_hit)
        r_addr <= PC[31:4];
      if (r_state == S_MEM_WAIT && !INST_MEM_BUSYWAIT)
        r_fillData <= INST_MEM_READDATA;
    end
  end

  // A flush seen mid-fill must keep the arriving line from becoming valid.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid     <= '0;
      r_pendFlush <= 1'b0;
    end else begin
      if (FLUSH)
        r_valid <= '0;
      else if (r_state == S_UPDATE)
        r_valid[w_fillIdx] <= !r_pendFlush;
      if (r_state == S_UPDATE)
        r_pendFlush <= 1'b0;
      else if (FLUSH && (r_state == S_MEM_REQ || r_state == S_MEM_WAIT))
        r_pendFlush <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (r_state == S_UPDATE) begin
      r_tag[w_fillIdx]  <= w_fillTag;
      r_data[w_fillIdx] <= r_fillData;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hitCount;
  logic [31:0] r_missCount;

  assign HIT_COUNT  = r_hitCount;
  assign MISS_COUNT = r_missCount;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hitCount  <= 32'h0;
      r_missCount <= 32'h0;
    end else begin
      if (w_hit)
        r_hitCount <= r_hitCount + 32'h1;
      if (r_state == S_IDLE && !w_hit)
        r_missCount <= r_missCount + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: line-level reference model plus directed scenarios.
// Define ICACHE_PERF_CNT_EN to also check the hit/miss counters.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic         FLUSH;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         INST_MEM_READ;
  logic [27:0]  INST_MEM_ADDRESS;
  logic [127:0] INST_MEM_READDATA;
  logic         INST_MEM_BUSYWAIT;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  int testsRun  = 0;
  int failCount = 0;
  int memLatency = 4;
  int memCnt = 0;
  int stalls;

  instruction_cache dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .PC                (PC),
    .FLUSH             (FLUSH),
    .INSTRUCTION       (INSTRUCTION),
    .BUSYWAIT          (BUSYWAIT),
    .INST_MEM_READ     (INST_MEM_READ),
    .INST_MEM_ADDRESS  (INST_MEM_ADDRESS),
    .INST_MEM_READDATA (INST_MEM_READDATA),
    .INST_MEM_BUSYWAIT (INST_MEM_BUSYWAIT)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .HIT_COUNT         (HIT_COUNT),
    .MISS_COUNT        (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Word w of a block is a fixed pattern xor'd with the byte address of the block.
  function automatic logic [127:0] lineOf(input logic [27:0] blk);
    logic [127:0] line;
    for (int w = 0; w < 4; w++)
      line[32*w +: 32] = (32'h11111111 * (w + 1)) ^ {blk, 4'h0};
    return line;
  endfunction

  // Memory stays busy for memLatency cycles once a read appears, then presents the line.
  assign INST_MEM_BUSYWAIT = INST_MEM_READ && (memCnt < memLatency);
  assign INST_MEM_READDATA = (INST_MEM_READ && !INST_MEM_BUSYWAIT) ?
                             lineOf(INST_MEM_ADDRESS) : {4{32'hDEADBEEF}};

  always @(posedge CLK) begin
    if (!INST_MEM_READ)           memCnt <= 0;
    else if (memCnt < memLatency) memCnt <= memCnt + 1;
  end

  // Reference model: lines keyed by full block address, a fill is a countdown of stall cycles.
  logic [7:0]   mValid;
  logic [27:0]  mBlk [8];
  logic [127:0] mLine [8];
  int           mFillLeft;
  logic [27:0]  mAddr;
  logic         mPend;
  int unsigned  mHits;
  int unsigned  mMisses;
  logic         mHit;
  logic [127:0] mCurLine;

  always_comb begin
    mHit     = (mFillLeft == 0) && mValid[PC[6:4]] && (mBlk[PC[6:4]] === PC[31:4]);
    mCurLine = mLine[PC[6:4]];
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mValid    <= '0;
      mPend     <= 1'b0;
      mFillLeft <= 0;
      mHits     <= 0;
      mMisses   <= 0;
    end else begin
      if (FLUSH) mValid <= '0;
      if (mFillLeft == 0) begin
        if (mHit) mHits <= mHits + 1;
        else begin
          mFillLeft <= memLatency + 2;
          mAddr     <= PC[31:4];
          mMisses   <= mMisses + 1;
        end
      end else begin
        mFillLeft <= mFillLeft - 1;
        if (mFillLeft == 1) begin
          mLine[mAddr[2:0]]  <= lineOf(mAddr);
          mBlk[mAddr[2:0]]   <= mAddr;
          mValid[mAddr[2:0]] <= !mPend && !FLUSH;
          mPend              <= 1'b0;
        end else if (FLUSH) begin
          mPend <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      checkOutput("model.busywait", {31'b0, BUSYWAIT}, {31'b0, !mHit});
      checkOutput("model.instruction", INSTRUCTION,
                  mHit ? mCurLine[{PC[3:2], 5'b00000} +: 32] : 32'h0);
      checkOutput("model.read", {31'b0, INST_MEM_READ}, {31'b0, mFillLeft >= 2});
      if (mFillLeft >= 2)
        checkOutput("model.address", {4'h0, INST_MEM_ADDRESS}, {4'h0, mAddr});
`ifdef ICACHE_PERF_CNT_EN
      checkOutput("model.hitCount", HIT_COUNT, mHits);
      checkOutput("model.missCount", MISS_COUNT, mMisses);
`endif
    end
  end

  task automatic applyStimulus(input logic [31:0] pc, input logic flush);
    @(posedge CLK);
    #2;
    PC    = pc;
    FLUSH = flush;
  endtask

  task automatic waitReady();
    int n = 0;
    while (BUSYWAIT && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("readyTimeout", {31'b0, BUSYWAIT}, 32'h0);
  endtask

  initial begin
    RESET = 1'b1;
    PC    = 32'h0;
    FLUSH = 1'b0;
    @(negedge CLK);
    checkOutput("reset.read", {31'b0, INST_MEM_READ}, 32'h0);
    checkOutput("reset.address", {4'h0, INST_MEM_ADDRESS}, 32'h0);
    checkOutput("reset.busywait", {31'b0, BUSYWAIT}, 32'h1);
    checkOutput("reset.instruction", INSTRUCTION, 32'h0);
    @(posedge CLK);
    #2;
    RESET = 1'b0;

    // Cold miss on PC 0 with a four-cycle memory: seven stall cycles
    @(negedge CLK);
    checkOutput("cold.read0", {31'b0, INST_MEM_READ}, 32'h0);
    @(negedge CLK);
    checkOutput("cold.read1", {31'b0, INST_MEM_READ}, 32'h1);
    checkOutput("cold.address", {4'h0, INST_MEM_ADDRESS}, 32'h0);
    stalls = 2;
    while (BUSYWAIT && stalls < 50) begin
      @(negedge CLK);
      if (BUSYWAIT) stalls++;
    end
    checkOutput("cold.stallCycles", stalls, 32'd7);
    checkOutput("cold.word0", INSTRUCTION, 32'h11111111);

    // Hit sweep over the rest of the line
    applyStimulus(32'h4, 1'b0);
    @(negedge CLK);
    checkOutput("sweep.word1", INSTRUCTION, 32'h22222222);
    checkOutput("sweep.busy1", {31'b0, BUSYWAIT}, 32'h0);
    applyStimulus(32'h8, 1'b0);
    @(negedge CLK);
    checkOutput("sweep.word2", INSTRUCTION, 32'h33333333);
    applyStimulus(32'hC, 1'b0);
    @(negedge CLK);
    checkOutput("sweep.word3", INSTRUCTION, 32'h44444444);
    checkOutput("sweep.read", {31'b0, INST_MEM_READ}, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
    checkOutput("perf.missCount", MISS_COUNT, 32'd1);
    checkOutput("perf.hitCount", HIT_COUNT, 32'd3);
`endif

    // Conflict on index 0
    applyStimulus(32'h80, 1'b0);
    @(negedge CLK);
    checkOutput("conflict.busy", {31'b0, BUSYWAIT}, 32'h1);
    @(negedge CLK);
    checkOutput("conflict.address", {4'h0, INST_MEM_ADDRESS}, 32'h8);
    waitReady();
    checkOutput("conflict.word0", INSTRUCTION, 32'h11111191);
    applyStimulus(32'h0, 1'b0);
    @(negedge CLK);
    checkOutput("conflict.remiss", {31'b0, BUSYWAIT}, 32'h1);
    waitReady();
    checkOutput("conflict.refill", INSTRUCTION, 32'h11111111);

    // Flush while the fill for 0x10 is waiting on memory
    applyStimulus(32'h10, 1'b0);
    applyStimulus(32'h10, 1'b0);
    applyStimulus(32'h10, 1'b1);
    applyStimulus(32'h10, 1'b0);
    repeat (4) @(negedge CLK);
    checkOutput("flushFill.readDropped", {31'b0, INST_MEM_READ}, 32'h0);
    @(negedge CLK);
    checkOutput("flushFill.remiss", {31'b0, BUSYWAIT}, 32'h1);
    @(negedge CLK);
    checkOutput("flushFill.reread", {31'b0, INST_MEM_READ}, 32'h1);
    checkOutput("flushFill.address", {4'h0, INST_MEM_ADDRESS}, 32'h1);
    waitReady();
    checkOutput("flushFill.word0", INSTRUCTION, 32'h11111101);

    // Flush alongside a hit: this cycle hits, the next misses
    applyStimulus(32'h10, 1'b1);
    @(negedge CLK);
    checkOutput("flushHit.hit", INSTRUCTION, 32'h11111101);
    applyStimulus(32'h10, 1'b0);
    @(negedge CLK);
    checkOutput("flushHit.miss", {31'b0, BUSYWAIT}, 32'h1);
    waitReady();

    // Reset in the middle of a fill with a shorter memory
    memLatency = 2;
    applyStimulus(32'h20, 1'b0);
    applyStimulus(32'h20, 1'b0);
    applyStimulus(32'h20, 1'b0);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("midReset.read", {31'b0, INST_MEM_READ}, 32'h0);
    checkOutput("midReset.address", {4'h0, INST_MEM_ADDRESS}, 32'h0);
    checkOutput("midReset.instruction", INSTRUCTION, 32'h0);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    PC    = 32'h0;
    @(negedge CLK);
    checkOutput("midReset.coldMiss", {31'b0, BUSYWAIT}, 32'h1);
    waitReady();
    checkOutput("midReset.word0", INSTRUCTION, 32'h11111111);
    applyStimulus(32'h28, 1'b0);
    @(negedge CLK);
    waitReady();
    checkOutput("short.word2", INSTRUCTION, 32'h33333313);

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
